// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared PWM defaults and capture FSM state encoding.
package pwm_capture_pkg;
    localparam int WIDTH_DEF = 12;
    localparam int SYNC_STAGES_DEF = 2;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_e;
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronizer chain plus previous-sample flop, yields s and its rising edge.
module pwm_edge_sync
    import pwm_capture_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pwm_i};
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign s_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in clk cycles, flags a stuck input.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] period_count,
    output logic             valid,
    output logic             stuck
);
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    logic             s;
    logic             rise;
    state_e           state_q;
    logic [WIDTH-1:0] per_q, per_d, hi_q, hi_d, high_q, period_q;
    logic             valid_q, stuck_q;
    pwm_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_i (pwm_in),
        .s_o   (s),
        .rise_o(rise)
    );
    always_comb begin
        per_d = (per_q == MAX) ? MAX : per_q + ONE;
        hi_d  = (s && hi_q != MAX) ? hi_q + ONE : hi_q;
    end
    // A rise always restarts the counters; only a rise seen in MEAS closes a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rise) begin
                per_q   <= ONE;
                hi_q    <= ONE;
                stuck_q <= 1'b0;
                state_q <= MEAS;
                if (state_q == MEAS) begin
                    high_q   <= hi_q;
                    period_q <= per_q;
                    valid_q  <= 1'b1;
                end
            end else if (state_q == MEAS) begin
                if (per_q == MAX) begin
                    state_q  <= STUCK;
                    period_q <= MAX;
                    high_q   <= s ? MAX : '0;
                    valid_q  <= 1'b1;
                    stuck_q  <= 1'b1;
                end else begin
                    per_q <= per_d;
                    hi_q  <= hi_d;
                end
            end
        end
    end
    assign high_count   = high_q;
    assign period_count = period_q;
    assign valid        = valid_q;
    assign stuck        = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus, sample-history reference model and queue scoreboard.
module tb_pwm_capture;
    localparam int W  = 12;
    localparam int ST = 2;
    localparam logic [W-1:0] MAXV = '1;
    localparam int MAXI = (1 << W) - 1;

    typedef struct {
        int         due;
        logic [W-1:0] h;
        logic [W-1:0] p;
        logic         s;
    } rep_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    logic [W-1:0] high_count, period_count;
    logic valid, stuck;

    pwm_capture #(.WIDTH(W), .SYNC_STAGES(ST)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .high_count  (high_count),
        .period_count(period_count),
        .valid       (valid),
        .stuck       (stuck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    bit armed = 0;
    rep_t sb[$];
    bit stk[$];
    logic [W-1:0] last_h = '0, last_p = '0;
    int nvalid = 0;

    // reference model state, in terms of synchronized-sample history
    bit measuring = 0, mstuck = 0, mprev = 0;
    int last_rise = 0, mhigh = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            armed = 1;
            measuring = 0;
            mstuck = 0;
            mprev = 0;
            mhigh = 0;
            sb.delete();
            stk.delete();
            for (int i = 0; i <= ST; i++) stk.push_back(1'b0);
            last_h = '0;
            last_p = '0;
        end else if (armed) begin
            bit x;
            rep_t r;
            x = pwm_in;
            if (x && !mprev) begin
                if (measuring) begin
                    r.due = edge_n + ST; r.h = W'(mhigh); r.p = W'(edge_n - last_rise); r.s = 1'b0;
                    sb.push_back(r);
                end
                measuring = 1;
                mstuck = 0;
                last_rise = edge_n;
                mhigh = 0;
            end else if (measuring && edge_n - last_rise == MAXI) begin
                r.due = edge_n + ST; r.h = x ? MAXV : '0; r.p = MAXV; r.s = 1'b1;
                sb.push_back(r);
                measuring = 0;
                mstuck = 1;
            end
            if (measuring && x) mhigh++;
            mprev = x;
            stk.push_back(mstuck);
            if (stk.size() > ST + 1) void'(stk.pop_front());
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (stuck !== stk[0]) begin
                failures++;
                $display("FAIL stuck_level edge=%0d got=%b exp=%b", edge_n, stuck, stk[0]);
            end
            checks++;
            if (valid === 1'b1) begin
                nvalid++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid edge=%0d got h=%0d p=%0d", edge_n, high_count, period_count);
                end else begin
                    rep_t e;
                    e = sb.pop_front();
                    if (e.due != edge_n || high_count !== e.h || period_count !== e.p || stuck !== e.s) begin
                        failures++;
                        $display("FAIL report edge=%0d got h=%0d p=%0d stuck=%b exp edge=%0d h=%0d p=%0d stuck=%b",
                                 edge_n, high_count, period_count, stuck, e.due, e.h, e.p, e.s);
                    end
                    last_h = e.h;
                    last_p = e.p;
                end
            end else if (valid !== 1'b0 || high_count !== last_h || period_count !== last_p) begin
                failures++;
                $display("FAIL hold edge=%0d got v=%b h=%0d p=%0d exp v=0 h=%0d p=%0d",
                         edge_n, valid, high_count, period_count, last_h, last_p);
            end else if (sb.size() != 0 && sb[0].due <= edge_n) begin
                rep_t e;
                e = sb.pop_front();
                failures++;
                $display("FAIL missing_valid edge=%0d exp h=%0d p=%0d due=%0d", edge_n, e.h, e.p, e.due);
                last_h = e.h;
                last_p = e.p;
            end
        end
    end

    task automatic hold(input bit v, input int c);
        for (int i = 0; i < c; i++) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 5);
        wave(100, 156, 4);
        wave(170, 342, 3);
        wave(42, 470, 3);
        hold(1'b0, 5000);
        wave(100, 156, 2);
        @(negedge clk);
        pwm_in = 1'b1;
        pulse_rst();
        hold(1'b1, 5000);
        hold(1'b0, 20);
        wave(50, 50, 2);
        hold(1'b1, 20);
        pulse_rst();
        hold(1'b1, 30);
        hold(1'b0, 50);
        wave(50, 50, 3);
        wave(1, 1, 10);
        wave(1000, 3095, 2);
        wave(1000, 3096, 1);
        wave(30, 40, 2);
        for (int i = 0; i < 15; i++) begin
            wave($urandom_range(1, 300), $urandom_range(1, 300), $urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) begin
                hold(1'b1, $urandom_range(1, 40));
                pulse_rst();
            end
        end
        hold(1'b0, 4200);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        checks++;
        if (nvalid < 20) begin
            failures++;
            $display("FAIL valid_count got=%0d exp>=20", nvalid);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
